// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 timing constants, RGB pixel type and the window
//                decode helper shared by the VGA scan logic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int unsigned c_h_vis  = 640;
    localparam int unsigned c_h_fp   = 16;
    localparam int unsigned c_h_sync = 96;
    localparam int unsigned c_h_bp   = 48;
    localparam int unsigned c_v_vis  = 480;
    localparam int unsigned c_v_fp   = 10;
    localparam int unsigned c_v_sync = 2;
    localparam int unsigned c_v_bp   = 33;

    localparam int unsigned c_h_tot = c_h_vis + c_h_fp + c_h_sync + c_h_bp;
    localparam int unsigned c_v_tot = c_v_vis + c_v_fp + c_v_sync + c_v_bp;

    localparam int unsigned c_h_sync_start = c_h_vis + c_h_fp;
    localparam int unsigned c_h_sync_end   = c_h_sync_start + c_h_sync - 1;
    localparam int unsigned c_v_sync_start = c_v_vis + c_v_fp;
    localparam int unsigned c_v_sync_end   = c_v_sync_start + c_v_sync - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // True when pos lies in [lo, lo+len).
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_en_div.sv
// ============================================================================
//  Module      : clk_en_div
//  Description : Divide-by-DIV clock enable; ce is high for one clk when the
//                divider reaches DIV-1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_en_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic o_ce
);

    localparam int unsigned W = $clog2(DIV);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(DIV - 1));
    assign o_ce   = w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// ============================================================================
//  Module      : vga_scan_ctrl
//  Description : VGA raster scan: pixel counters, sync decode and a registered
//                output stage that lags the published scan position by one pixel.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = c_h_vis,
    parameter int unsigned H_FP    = c_h_fp,
    parameter int unsigned H_SYNC  = c_h_sync,
    parameter int unsigned H_BP    = c_h_bp,
    parameter int unsigned V_VIS   = c_v_vis,
    parameter int unsigned V_FP    = c_v_fp,
    parameter int unsigned V_SYNC  = c_v_sync,
    parameter int unsigned V_BP    = c_v_bp
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        color_in,
    output logic signed [15:0] pix_x,
    output logic signed [15:0] pix_y,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               frame_tick
);

    localparam int unsigned H_TOT        = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT        = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW           = $clog2(H_TOT);
    localparam int unsigned VW           = $clog2(V_TOT);
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;

    logic          w_pix_ce;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    logic          r_frame_wrap;
    logic          r_frame_tick;
    logic [15:0]   r_pix_x;
    logic [15:0]   r_pix_y;
    logic          w_raw_vis;
    logic          w_raw_hsync;
    logic          w_raw_vsync;
    logic          r_hsync;
    logic          r_vsync;
    rgb_t          r_rgb;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk   (clk),
        .reset (reset),
        .o_ce  (w_pix_ce)
    );

    assign w_h_last = (r_h_cnt == HW'(H_TOT - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_frame_wrap <= 1'b0;
        end else begin
            r_frame_wrap <= w_pix_ce && w_h_last && w_v_last;
            if (w_pix_ce) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    // Published position trails the counters by one clk; frame_tick lines up
    // with the clk on which the published position returns to (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pix_x      <= 16'(r_h_cnt);
            r_pix_y      <= 16'(r_v_cnt);
            r_frame_tick <= r_frame_wrap;
        end
    end

    assign w_raw_vis   = (r_pix_x < 16'(H_VIS)) && (r_pix_y < 16'(V_VIS));
    assign w_raw_hsync = !in_window(32'(r_pix_x), H_SYNC_START, H_SYNC);
    assign w_raw_vsync = !in_window(32'(r_pix_y), V_SYNC_START, V_SYNC);

    // Sampling on the next pix_ce gives the renderer CLK_DIV-1 clks to settle
    // and keeps colour and sync from the same pixel together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else if (w_pix_ce) begin
            r_hsync <= w_raw_hsync;
            r_vsync <= w_raw_vsync;
            r_rgb   <= w_raw_vis ? rgb_t'(color_in) : '0;
        end
    end

    assign pix_x      = $signed(r_pix_x);
    assign pix_y      = $signed(r_pix_y);
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign vga_r      = r_rgb.r;
    assign vga_g      = r_rgb.g;
    assign vga_b      = r_rgb.b;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
//  Module      : tb_vga_scan_ctrl
//  Description : Scoreboard bench for vga_scan_ctrl on a reduced raster.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_ctrl;

    localparam int DIV = 4;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [11:0]        color_in = 12'h000;
    logic signed [15:0] pix_x;
    logic signed [15:0] pix_y;
    logic               hsync;
    logic               vsync;
    logic [3:0]         vga_r;
    logic [3:0]         vga_g;
    logic [3:0]         vga_b;
    logic               frame_tick;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int mode = 0;

    typedef struct {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];

    vga_scan_ctrl #(
        .CLK_DIV (DIV),
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .color_in   (color_in),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Clocks since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t k=%0d)", name, act, req, $time, k);
        end
    endtask

    function automatic logic visible(input int q);
        return ((q % HT) < HV) && (((q / HT) % VT) < VV);
    endfunction

    function automatic exp_t expect_for(input int q, input logic [11:0] c);
        int h;
        int v;
        exp_t e;
        h = q % HT;
        v = (q / HT) % VT;
        e.hs  = !(h >= HV + HF && h < HV + HF + HS);
        e.vs  = !(v >= VV + VF && v < VV + VF + VS);
        e.rgb = (h < HV && v < VV) ? c : 12'h000;
        return e;
    endfunction

    function automatic logic [11:0] render(input logic [15:0] x, input logic [15:0] y);
        return {x[3:0], y[3:0], x[3:0] ^ y[3:0]};
    endfunction

    // Renderer + stimulus: the value held into a pix_ce edge is the one
    // the output stage must show; other clks may carry noise.
    initial begin : driver
        int q;
        logic [11:0] good;
        forever begin
            @(negedge clk);
            if (reset) begin
                good = (mode == 0) ? 12'hF00 : render(pix_x, pix_y);
                if ((k + 1) % DIV == 0) begin
                    q = (k + 1) / DIV - 1;
                    if (mode == 2 && !visible(q)) good = 12'($urandom);
                    color_in = good;
                    exp_q.push_back(expect_for(q, good));
                end else begin
                    color_in = (mode == 2) ? 12'($urandom) : good;
                end
            end
        end
    end

    initial begin : monitor
        logic p_hs, p_vs;
        logic [11:0] p_rgb;
        int hrun, vrun, last_tick, q;
        bit tick_val;
        logic exp_tick;
        exp_t e;
        p_hs = 1'b1; p_vs = 1'b1; p_rgb = 12'h000;
        hrun = 0; vrun = 0; last_tick = 0; tick_val = 0;
        forever begin
            @(negedge clk);
            if (!reset || k == 0) begin
                exp_q.delete();
                chk("reset_outputs", 32'({hsync, vsync, vga_r, vga_g, vga_b, frame_tick}),
                    32'({2'b11, 12'h000, 1'b0}));
                chk("reset_pix", 32'({pix_x, pix_y}), 32'(0));
                p_hs = 1'b1; p_vs = 1'b1; p_rgb = 12'h000;
                hrun = 0; vrun = 0; tick_val = 0;
            end else begin
                q = (k - 1) / DIV;
                chk("pix_x", 32'(pix_x), 32'(q % HT));
                chk("pix_y", 32'(pix_y), 32'((q / HT) % VT));
                exp_tick = (k > 1) && ((k - 1) % DIV == 0) && (q % FRAME == 0);
                chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
                if (k % DIV == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got no expectation at k=%0d", k);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_update", 32'({hsync, vsync, vga_r, vga_g, vga_b}),
                            32'({e.hs, e.vs, e.rgb}));
                    end
                end else begin
                    chk("out_stable", 32'({hsync, vsync, vga_r, vga_g, vga_b}),
                        32'({p_hs, p_vs, p_rgb}));
                end
                if (!hsync) hrun = p_hs ? 1 : hrun + 1;
                else if (!p_hs) chk("hsync_len", 32'(hrun), 32'(HS * DIV));
                if (!vsync) vrun = p_vs ? 1 : vrun + 1;
                else if (!p_vs) chk("vsync_len", 32'(vrun), 32'(VS * HT * DIV));
                if (frame_tick) begin
                    if (tick_val) chk("tick_gap", 32'(k - last_tick), 32'(FRAME * DIV));
                    last_tick = k;
                    tick_val = 1;
                end
                p_hs = hsync; p_vs = vsync; p_rgb = {vga_r, vga_g, vga_b};
            end
        end
    end

    initial begin : main
        bit found;
        reset = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2 * HT * DIV) @(posedge clk);
        mode = 1;
        repeat (FRAME * DIV) @(posedge clk);
        mode = 2;
        repeat (FRAME * DIV + FRAME * DIV / 2) @(posedge clk);

        // Reset mid-pixel while both sync pulses are active.
        found = 0;
        for (int i = 0; i < FRAME * DIV + 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pix_x == 16'(HV + HF + 2) && pix_y == 16'(VV + VF + 1)) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reset_target: position not reached within budget");
        end else begin
            chk("pre_reset_syncs", 32'({hsync, vsync}), 32'(2'b00));
            @(posedge clk);
            #3 reset = 1'b0;
            #1;
            chk("async_reset_out", 32'({hsync, vsync, vga_r, vga_g, vga_b, frame_tick}),
                32'({2'b11, 12'h000, 1'b0}));
            chk("async_reset_pix", 32'({pix_x, pix_y}), 32'(0));
        end
        mode = 0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2 * FRAME * DIV + 20) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
